main_memory_responder: RTL

//   Clocked main-memory model on the memory side of the cache/memory interface.

---
 rtl/main_memory_responder_if.sv | 24 ++
 rtl/main_memory_responder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/main_memory_responder_if.sv
// Cache <-> main-memory request/response bundle.
// The cache drives the master side; the memory model drives the slave side.
interface main_memory_responder_if #(
  parameter int ADDR_W = 10
);
  logic              isLock;
  logic              isMemRead;
  logic [ADDR_W-1:0] address;
  logic [127:0]      memWriteData;
  logic [3:0]        isDirty;
  logic [127:0]      memReadData;
  logic              memReady;
  logic              memBusy;

  modport master (
    output isLock, isMemRead, address, memWriteData, isDirty,
    input  memReadData, memReady, memBusy
  );

  modport slave (
    input  isLock, isMemRead, address, memWriteData, isDirty,
    output memReadData, memReady, memBusy
  );
endinterface

// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory model: 128-bit block reads, word-masked writes.
// A request starts on a high->low transition of isLock and completes with a 1-cycle memReady pulse.
module main_memory_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  main_memory_responder_if.slave bus
);

  localparam int LINE_W = ADDR_W - 4;
  localparam int LINES  = 1 << LINE_W;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [7:0]        cnt;
  logic [7:0]        cntNext;
  logic              lockQ;
  logic              readyQ;
  logic              readyNext;
  logic              busyQ;
  logic              busyNext;
  logic [127:0]      readDataQ;
  logic              accept;
  logic              doAccess;

  logic              reqRead;
  logic [LINE_W-1:0] reqLine;
  logic [31:0]       reqData;
  logic [3:0]        reqMask;
  logic [127:0]      mergedLine;

  // Contents survive reset; only the power-up value is zero.
  logic [127:0]      mem [LINES] = '{default: '0};

  logic              unusedBits;
  assign unusedBits = ^{bus.memWriteData[127:32], bus.address[3:0]};

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    readyNext = 1'b0;
    busyNext  = busyQ;
    accept    = 1'b0;
    doAccess  = 1'b0;
    case (state)
      IDLE: begin
        if (lockQ && !bus.isLock) begin
          accept    = 1'b1;
          stateNext = BUSY;
          cntNext   = LAT_M1;
          busyNext  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 8'd0) begin
          cntNext = cnt - 8'd1;
        end else begin
          stateNext = DONE;
          doAccess  = 1'b1;
          readyNext = 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Word k lives at bits [(3-k)*32 +: 32]; every selected word gets the same 32-bit value.
  always_comb begin
    mergedLine = mem[reqLine];
    for (int unsigned k = 0; k < 4; k++) begin
      if (reqMask[k]) begin
        mergedLine[(3 - k) * 32 +: 32] = reqData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lockQ     <= 1'b1;
      readyQ    <= 1'b0;
      busyQ     <= 1'b0;
      readDataQ <= '0;
      reqRead   <= 1'b0;
      reqLine   <= '0;
      reqData   <= '0;
      reqMask   <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      lockQ  <= bus.isLock;
      readyQ <= readyNext;
      busyQ  <= busyNext;
      if (accept) begin
        reqRead <= bus.isMemRead;
        reqLine <= bus.address[ADDR_W-1:4];
        reqData <= bus.memWriteData[31:0];
        reqMask <= bus.isDirty;
      end
      if (doAccess && reqRead) begin
        readDataQ <= mem[reqLine];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && doAccess && !reqRead) begin
      mem[reqLine] <= mergedLine;
    end
  end

  assign bus.memReadData = readDataQ;
  assign bus.memReady    = readyQ;
  assign bus.memBusy     = busyQ;

endmodule
